// File: rtl/rle_job_scheduler.sv
// Job FIFO plus sequencer that runs queued RLE jobs one at a time on a single core
// and returns compressed size, latency and timeout status through a result handshake.
module rle_job_scheduler #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned LAT_W        = 16,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 10,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [31:0]                job_msg_addr,
  input  logic [31:0]                job_msg_size,
  input  logic [31:0]                job_rle_addr,
  input  logic [TAG_W-1:0]           job_tag,
  output logic                       rle_start,
  output logic [31:0]                rle_message_addr,
  output logic [31:0]                rle_message_size,
  output logic [31:0]                rle_rle_addr,
  input  logic [31:0]                rle_size,
  input  logic                       rle_done,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TAG_W-1:0]           res_tag,
  output logic [31:0]                res_rle_size,
  output logic [LAT_W-1:0]           res_latency,
  output logic                       res_timeout,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENTRY_W = 96 + TAG_W;
  localparam int unsigned SC_W    = $clog2(START_CYCLES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_RESULT} state_t;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  state_t             state_q;
  logic [GAP_W-1:0]   gap_q;
  logic [SC_W-1:0]    start_cnt_q;
  logic [TO_W-1:0]    wait_cnt_q;
  logic [LAT_W-1:0]   lat_q;
  logic               rle_start_q;
  logic [31:0]        msg_addr_q, msg_size_q, rle_addr_q;
  logic               res_valid_q, res_timeout_q;
  logic [TAG_W-1:0]   res_tag_q;
  logic [31:0]        res_rle_size_q;
  logic [LAT_W-1:0]   res_latency_q;

  logic               push_c, pop_c;
  logic [31:0]        head_msg_addr_c, head_msg_size_c, head_rle_addr_c;
  logic [TAG_W-1:0]   head_tag_c;
  logic [LAT_W-1:0]   lat_inc_c;

  assign job_ready = (count_q != CNT_W'(DEPTH));
  assign push_c    = job_valid && job_ready;
  // Head is only consumed when the sequencer is idle and the inter-job gap has elapsed.
  assign pop_c     = (state_q == S_IDLE) && (gap_q == '0) && (count_q != '0);
  assign {head_tag_c, head_rle_addr_c, head_msg_size_c, head_msg_addr_c} = mem_q[rd_ptr_q];
  assign lat_inc_c = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

  // Job storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {job_tag, job_rle_addr, job_msg_size, job_msg_addr};
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q        <= S_IDLE;
      gap_q          <= '0;
      start_cnt_q    <= '0;
      wait_cnt_q     <= '0;
      lat_q          <= '0;
      rle_start_q    <= 1'b0;
      msg_addr_q     <= '0;
      msg_size_q     <= '0;
      rle_addr_q     <= '0;
      res_valid_q    <= 1'b0;
      res_timeout_q  <= 1'b0;
      res_tag_q      <= '0;
      res_rle_size_q <= '0;
      res_latency_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
          end else if (pop_c) begin
            msg_addr_q <= head_msg_addr_c;
            msg_size_q <= head_msg_size_c;
            rle_addr_q <= head_rle_addr_c;
            res_tag_q  <= head_tag_c;
            // Empty jobs never touch the core.
            if (head_msg_size_c == '0) begin
              res_valid_q    <= 1'b1;
              res_timeout_q  <= 1'b0;
              res_rle_size_q <= '0;
              res_latency_q  <= '0;
              state_q        <= S_RESULT;
            end else begin
              rle_start_q <= 1'b1;
              start_cnt_q <= '0;
              lat_q       <= LAT_W'(1);
              state_q     <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          lat_q <= lat_inc_c;
          if (start_cnt_q == SC_W'(START_CYCLES - 1)) begin
            rle_start_q <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= S_WAIT_DONE;
          end else begin
            start_cnt_q <= start_cnt_q + SC_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (rle_done) begin
            res_valid_q    <= 1'b1;
            res_timeout_q  <= 1'b0;
            res_rle_size_q <= rle_size;
            res_latency_q  <= lat_q;
            state_q        <= S_RESULT;
          end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
            res_valid_q    <= 1'b1;
            res_timeout_q  <= 1'b1;
            res_rle_size_q <= '0;
            res_latency_q  <= lat_q;
            state_q        <= S_RESULT;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
            lat_q      <= lat_inc_c;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            gap_q       <= GAP_W'(GAP_CYCLES);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rle_start        = rle_start_q;
  assign rle_message_addr = msg_addr_q;
  assign rle_message_size = msg_size_q;
  assign rle_rle_addr     = rle_addr_q;
  assign res_valid        = res_valid_q;
  assign res_tag          = res_tag_q;
  assign res_rle_size     = res_rle_size_q;
  assign res_latency      = res_latency_q;
  assign res_timeout      = res_timeout_q;
  assign busy             = (state_q != S_IDLE) || (count_q != '0);
  assign queue_count      = count_q;

endmodule

// File: tb/tb_rle_job_scheduler.sv
// Self-checking bench for rle_job_scheduler: behavioural core model plus an
// in-order scoreboard of expected results derived from the job/response tables.
module tb_rle_job_scheduler;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned TAG_W        = 4;
  localparam int unsigned LAT_W        = 16;
  localparam int unsigned START_CYCLES = 2;
  localparam int unsigned GAP_CYCLES   = 10;
  localparam int unsigned TIMEOUT      = 64;
  localparam int unsigned CNT_W        = $clog2(DEPTH + 1);

  logic              clk;
  logic              nreset;
  logic              job_valid, job_ready;
  logic [31:0]       job_msg_addr, job_msg_size, job_rle_addr;
  logic [TAG_W-1:0]  job_tag;
  logic              rle_start;
  logic [31:0]       rle_message_addr, rle_message_size, rle_rle_addr;
  logic [31:0]       rle_size;
  logic              rle_done;
  logic              res_valid, res_ready;
  logic [TAG_W-1:0]  res_tag;
  logic [31:0]       res_rle_size;
  logic [LAT_W-1:0]  res_latency;
  logic              res_timeout;
  logic              busy;
  logic [CNT_W-1:0]  queue_count;

  rle_job_scheduler #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .LAT_W(LAT_W), .START_CYCLES(START_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .nreset(nreset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_msg_addr(job_msg_addr), .job_msg_size(job_msg_size),
    .job_rle_addr(job_rle_addr), .job_tag(job_tag),
    .rle_start(rle_start), .rle_message_addr(rle_message_addr),
    .rle_message_size(rle_message_size), .rle_rle_addr(rle_rle_addr),
    .rle_size(rle_size), .rle_done(rle_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_rle_size(res_rle_size), .res_latency(res_latency),
    .res_timeout(res_timeout), .busy(busy), .queue_count(queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          delay;
    logic [31:0] sz;
  } resp_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      sz;
    logic [LAT_W-1:0] lat;
    logic             tmo;
  } exp_t;

  resp_t core_q[$];
  exp_t  exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int push_fail = 0;

  int          launch_cnt = 0;
  int          start_len = 0;
  int          last_start_len = 0;
  logic [31:0] launch_addr = '0, launch_size = '0, launch_raddr = '0;

  // Core model: takes the next response on each launch, raises done 'delay'
  // cycles after start falls (delay 0 = never), done held until the next launch ends.
  initial begin
    bit          prev_start;
    bit          active;
    int          cnt;
    int          delay;
    logic [31:0] rsz;
    resp_t       r;
    prev_start = 0; active = 0; cnt = 0; delay = 0; rsz = '0;
    rle_done = 1'b0;
    rle_size = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        rle_done = 1'b0;
        rle_size = '0;
        active   = 0;
        start_len = 0;
        prev_start = 0;
      end else begin
        if (rle_start) begin
          if (!prev_start) begin
            launch_cnt++;
            start_len    = 0;
            launch_addr  = rle_message_addr;
            launch_size  = rle_message_size;
            launch_raddr = rle_rle_addr;
            if (core_q.size() > 0) begin
              r = core_q.pop_front();
              delay = r.delay;
              rsz   = r.sz;
            end else begin
              delay = 0;
              rsz   = '0;
            end
            active = 1;
            cnt    = 0;
          end
          start_len++;
        end else begin
          if (prev_start) begin
            last_start_len = start_len;
            rle_done = 1'b0;
          end
          if (active) begin
            cnt++;
            if (delay != 0 && cnt == delay) begin
              rle_done = 1'b1;
              rle_size = rsz;
              active   = 0;
            end
          end
        end
        prev_start = rle_start;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog expired");
  end

  // Expected result from the job and the core's response.
  task automatic enqueue_job(input logic [31:0] s, input logic [TAG_W-1:0] t,
                             input int d, input logic [31:0] rs);
    exp_t e;
    resp_t r;
    e.tag = t;
    if (s == 0) begin
      e.sz = '0; e.lat = '0; e.tmo = 1'b0;
    end else begin
      r.delay = d;
      r.sz    = rs;
      core_q.push_back(r);
      if (d == 0 || d > int'(TIMEOUT)) begin
        e.sz = '0; e.lat = LAT_W'(START_CYCLES + TIMEOUT); e.tmo = 1'b1;
      end else begin
        e.sz = rs; e.lat = LAT_W'(int'(START_CYCLES) + d); e.tmo = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic push_job(input logic [31:0] a, input logic [31:0] s, input logic [31:0] r,
                          input logic [TAG_W-1:0] t);
    int n;
    bit ok;
    n = 0; ok = 0;
    job_msg_addr = a; job_msg_size = s; job_rle_addr = r; job_tag = t;
    job_valid = 1'b1;
    while (!ok && n < 400) begin
      if (job_ready) begin
        @(posedge clk);
        ok = 1;
      end
      @(negedge clk);
      n++;
    end
    job_valid = 1'b0;
    if (!ok) push_fail++;
  endtask

  task automatic submit(input logic [31:0] a, input logic [31:0] s, input logic [31:0] r,
                        input logic [TAG_W-1:0] t, input int d, input logic [31:0] rs);
    enqueue_job(s, t, d, rs);
    push_job(a, s, r, t);
  endtask

  task automatic get_result(input int stall, output bit got, output logic [TAG_W-1:0] tag,
                            output logic [31:0] sz, output logic [LAT_W-1:0] lat, output logic tmo);
    int n;
    n = 0; got = 0; tag = '0; sz = '0; lat = '0; tmo = 1'b0;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (res_valid) begin
      repeat (stall) @(negedge clk);
      tag = res_tag; sz = res_rle_size; lat = res_latency; tmo = res_timeout;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      got = 1;
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
    job_msg_addr = '0; job_msg_size = '0; job_rle_addr = '0; job_tag = '0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({job_ready, busy, queue_count} !== {1'b1, 1'b0, CNT_W'(0)}) begin
      $display("FAIL reset_queue: ready=%b busy=%b count=%0d, want ready=1 busy=0 count=0",
               job_ready, busy, queue_count);
    end else n_pass++;
    n_checks++;
    if ({rle_start, rle_message_addr, rle_message_size, rle_rle_addr} !== '0) begin
      $display("FAIL reset_core_if: start=%b addr=%0h size=%0d rle=%0h, want all 0",
               rle_start, rle_message_addr, rle_message_size, rle_rle_addr);
    end else n_pass++;
    n_checks++;
    if ({res_valid, res_tag, res_rle_size, res_latency, res_timeout} !== '0) begin
      $display("FAIL reset_result: valid=%b tag=%0d size=%0d lat=%0d to=%b, want all 0",
               res_valid, res_tag, res_rle_size, res_latency, res_timeout);
    end else n_pass++;
  endtask

  task automatic test_single_job();
    bit got; logic [TAG_W-1:0] t; logic [31:0] s; logic [LAT_W-1:0] l; logic o;
    exp_t e;
    submit(32'h0, 32'd48, 32'hC8, 4'd1, 30, 32'd12);
    get_result(0, got, t, s, l, o);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {t, s, l, o} !== {e.tag, e.sz, e.lat, e.tmo}) begin
      $display("FAIL single_result: got=%0b tag=%0d size=%0d lat=%0d to=%b, want tag=%0d size=%0d lat=%0d to=%b",
               got, t, s, l, o, e.tag, e.sz, e.lat, e.tmo);
    end else n_pass++;
    n_checks++;
    if (last_start_len !== int'(START_CYCLES)) begin
      $display("FAIL single_start_width: got %0d cycles, want %0d", last_start_len, START_CYCLES);
    end else n_pass++;
    n_checks++;
    if ({launch_addr, launch_size, launch_raddr} !== {32'h0, 32'd48, 32'hC8}) begin
      $display("FAIL single_core_fields: addr=%0h size=%0d rle=%0h, want 0/48/c8",
               launch_addr, launch_size, launch_raddr);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit got; logic [TAG_W-1:0] t; logic [31:0] s; logic [LAT_W-1:0] l; logic o;
    exp_t e;
    int c;
    submit(32'h0,  32'd48, 32'hC8,  4'd2, 30, 32'd12);
    submit(32'h30, 32'd51, 32'h12C, 4'd3, 20, 32'd76);
    get_result(0, got, t, s, l, o);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {t, s, l, o} !== {e.tag, e.sz, e.lat, e.tmo}) begin
      $display("FAIL b2b_first: got=%0b tag=%0d size=%0d lat=%0d to=%b, want tag=%0d size=%0d lat=%0d to=%b",
               got, t, s, l, o, e.tag, e.sz, e.lat, e.tmo);
    end else n_pass++;
    c = 1;
    while (!rle_start && c < 100) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (!rle_start || c < int'(GAP_CYCLES) + 1 || c > int'(GAP_CYCLES) + 3) begin
      $display("FAIL b2b_gap: second start seen in cycle %0d after accept (start=%b), want %0d..%0d",
               c, rle_start, GAP_CYCLES + 1, GAP_CYCLES + 3);
    end else n_pass++;
    get_result(0, got, t, s, l, o);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {t, s, l, o} !== {e.tag, e.sz, e.lat, e.tmo}) begin
      $display("FAIL b2b_second: got=%0b tag=%0d size=%0d lat=%0d to=%b, want tag=%0d size=%0d lat=%0d to=%b",
               got, t, s, l, o, e.tag, e.sz, e.lat, e.tmo);
    end else n_pass++;
    n_checks++;
    if ({launch_addr, launch_size, launch_raddr} !== {32'h30, 32'd51, 32'h12C}) begin
      $display("FAIL b2b_core_fields: addr=%0h size=%0d rle=%0h, want 30/51/12c",
               launch_addr, launch_size, launch_raddr);
    end else n_pass++;
  endtask

  task automatic test_zero_job();
    bit got; logic [TAG_W-1:0] t; logic [31:0] s; logic [LAT_W-1:0] l; logic o;
    exp_t e;
    int l0;
    l0 = launch_cnt;
    submit(32'h100, 32'd0, 32'h200, 4'd10, 0, 32'd0);
    get_result(1, got, t, s, l, o);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {t, s, l, o} !== {e.tag, e.sz, e.lat, e.tmo}) begin
      $display("FAIL zero_result: got=%0b tag=%0d size=%0d lat=%0d to=%b, want tag=%0d size=%0d lat=%0d to=%b",
               got, t, s, l, o, e.tag, e.sz, e.lat, e.tmo);
    end else n_pass++;
    n_checks++;
    if (launch_cnt !== l0) begin
      $display("FAIL zero_no_start: launches=%0d, want %0d", launch_cnt, l0);
    end else n_pass++;
  endtask

  task automatic test_timeout();
    bit got; logic [TAG_W-1:0] t; logic [31:0] s; logic [LAT_W-1:0] l; logic o;
    exp_t e;
    submit(32'h400, 32'd100, 32'h500, 4'd11, 0, 32'd99);
    submit(32'h600, 32'd20,  32'h700, 4'd12, 7, 32'd5);
    for (int k = 0; k < 2; k++) begin
      get_result(0, got, t, s, l, o);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || {t, s, l, o} !== {e.tag, e.sz, e.lat, e.tmo}) begin
        $display("FAIL timeout_result%0d: got=%0b tag=%0d size=%0d lat=%0d to=%b, want tag=%0d size=%0d lat=%0d to=%b",
                 k, got, t, s, l, o, e.tag, e.sz, e.lat, e.tmo);
      end else n_pass++;
    end
    n_checks++;
    if (launch_addr !== 32'h600) begin
      $display("FAIL timeout_next_launch: addr=%0h, want 600", launch_addr);
    end else n_pass++;
  endtask

  task automatic test_fifo_full();
    bit got; logic [TAG_W-1:0] t; logic [31:0] s; logic [LAT_W-1:0] l; logic o;
    exp_t e;
    int n;
    bit held;
    submit(32'h800, 32'd0, 32'h900, 4'd4, 0, 32'd0);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++)
      submit(32'h1000 + 32'(i * 64), 32'($urandom_range(1, 2000)), 32'h2000 + 32'(i * 64),
             TAG_W'(5 + i), int'($urandom_range(1, 30)), $urandom);
    n_checks++;
    if ({queue_count, job_ready, busy} !== {CNT_W'(DEPTH), 1'b0, 1'b1}) begin
      $display("FAIL fifo_full_flags: count=%0d ready=%b busy=%b, want %0d/0/1",
               queue_count, job_ready, busy, DEPTH);
    end else n_pass++;
    enqueue_job(32'd77, 4'd9, 12, 32'd4242);
    job_msg_addr = 32'h3000; job_msg_size = 32'd77; job_rle_addr = 32'h4000; job_tag = 4'd9;
    job_valid = 1'b1;
    held = 1;
    repeat (6) begin
      @(negedge clk);
      if (job_ready !== 1'b0 || queue_count !== CNT_W'(DEPTH)) held = 0;
    end
    n_checks++;
    if (!held) begin
      $display("FAIL fifo_fifth_held: ready=%b count=%0d, want 0/%0d", job_ready, queue_count, DEPTH);
    end else n_pass++;
    get_result(2, got, t, s, l, o);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {t, s, l, o} !== {e.tag, e.sz, e.lat, e.tmo}) begin
      $display("FAIL fifo_blocker: got=%0b tag=%0d size=%0d lat=%0d to=%b, want tag=%0d size=%0d lat=%0d to=%b",
               got, t, s, l, o, e.tag, e.sz, e.lat, e.tmo);
    end else n_pass++;
    push_job(32'h3000, 32'd77, 32'h4000, 4'd9);
    for (int k = 0; k < 5; k++) begin
      get_result(0, got, t, s, l, o);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || {t, s, l, o} !== {e.tag, e.sz, e.lat, e.tmo}) begin
        $display("FAIL fifo_order%0d: got=%0b tag=%0d size=%0d lat=%0d to=%b, want tag=%0d size=%0d lat=%0d to=%b",
                 k, got, t, s, l, o, e.tag, e.sz, e.lat, e.tmo);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid_job();
    int l0, n;
    bit quiet;
    l0 = launch_cnt;
    submit(32'h5000, 32'd60, 32'h6000, 4'd13, 50, 32'd1);
    submit(32'h5100, 32'd61, 32'h6100, 4'd14, 5, 32'd2);
    submit(32'h5200, 32'd62, 32'h6200, 4'd15, 5, 32'd3);
    n = 0;
    while ((launch_cnt == l0 || rle_start) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (queue_count !== CNT_W'(2) || res_valid !== 1'b0) begin
      $display("FAIL midrst_setup: count=%0d valid=%b, want 2/0", queue_count, res_valid);
    end else n_pass++;
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    n_checks++;
    if ({rle_start, res_valid, queue_count, job_ready, busy} !== {1'b0, 1'b0, CNT_W'(0), 1'b1, 1'b0}) begin
      $display("FAIL midrst_state: start=%b valid=%b count=%0d ready=%b busy=%b, want 0/0/0/1/0",
               rle_start, res_valid, queue_count, job_ready, busy);
    end else n_pass++;
    core_q.delete();
    exp_q.delete();
    l0 = launch_cnt;
    quiet = 1;
    repeat (40) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || rle_start !== 1'b0) quiet = 0;
    end
    n_checks++;
    if (!quiet || launch_cnt !== l0) begin
      $display("FAIL midrst_quiet: activity after reset, launches %0d->%0d", l0, launch_cnt);
    end else n_pass++;
  endtask

  task automatic test_random();
    fork
      begin
        logic [31:0] sz;
        int d;
        for (int i = 0; i < 12; i++) begin
          sz = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
          d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
          submit($urandom & 32'hFFFF_FFFC, sz, $urandom & 32'hFFFF_FFFC, TAG_W'(i), d, $urandom);
          repeat ($urandom_range(0, 15)) @(negedge clk);
        end
      end
      begin
        bit got; logic [TAG_W-1:0] t; logic [31:0] s; logic [LAT_W-1:0] l; logic o;
        exp_t e;
        for (int k = 0; k < 12; k++) begin
          get_result(int'($urandom_range(0, 3)), got, t, s, l, o);
          e = exp_q.pop_front();
          n_checks++;
          if (!got || {t, s, l, o} !== {e.tag, e.sz, e.lat, e.tmo}) begin
            $display("FAIL random%0d: got=%0b tag=%0d size=%0d lat=%0d to=%b, want tag=%0d size=%0d lat=%0d to=%b",
                     k, got, t, s, l, o, e.tag, e.sz, e.lat, e.tmo);
          end else n_pass++;
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_zero_job();
    test_timeout();
    test_fifo_full();
    test_reset_mid_job();
    test_random();
    n_checks++;
    if (push_fail != 0 || exp_q.size() != 0) begin
      $display("FAIL drain: push timeouts=%0d leftover results=%0d, want 0/0", push_fail, exp_q.size());
    end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
